// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment pattern constants, decode/encode helpers and scan FSM state type
// Patterns are abcdefg, active-low (0 = lit segment); bit indices refer to the 8-bit bus a..g,dp.
package seg7_pkg;
   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;
   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   typedef enum logic [1:0] {BLANK, SETTLE, CAPTURED} scan_state_t;
   function automatic logic [3:0] seg7_decode(input logic [6:0] p);
      case (p)
         SEG_0:   return 4'd0;
         SEG_1:   return 4'd1;
         SEG_2:   return 4'd2;
         SEG_3:   return 4'd3;
         SEG_4:   return 4'd4;
         SEG_5:   return 4'd5;
         SEG_6:   return 4'd6;
         SEG_7:   return 4'd7;
         SEG_8:   return 4'd8;
         SEG_9:   return 4'd9;
         default: return 4'hF;
      endcase
   endfunction
   function automatic logic [6:0] seg7_encode(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction
endpackage

// File: rtl/seg_sync_stable.sv
// seg_sync_stable: 2-flop synchronizer for the display bus plus a stability filter
// Ports: clk, rst (sync, active-low); seg_in/anode_in raw bus; anode_s synchronized anodes;
// smp_seg/smp_anode the held sample; accept pulses in the cycle the sample has been stable
// for STABLE_CYCLES consecutive samples on exactly one low anode.
module seg_sync_stable
   import seg7_pkg::*;
#(
   parameter int N_DIG         = 4,
   parameter int STABLE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       seg_in,
   input  logic [N_DIG-1:0] anode_in,
   output logic [N_DIG-1:0] anode_s,
   output logic [7:0]       smp_seg,
   output logic [N_DIG-1:0] smp_anode,
   output logic             accept
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int SW = 8 + N_DIG;
   logic [SW-1:0] m1, m2, smp, smp_n;
   logic [CW-1:0] cnt, cnt_n;
   scan_state_t   state, state_n;
   logic          same, one;
   assign anode_s              = m2[SW-1:8];
   assign {smp_anode, smp_seg} = smp;
   assign same                 = m2 == smp;
   assign one                  = $onehot(~m2[SW-1:8]);
   always_ff @(posedge clk)
      if (!rst) begin
         m1    <= '1;
         m2    <= '1;
         smp   <= '1;
         cnt   <= '0;
         state <= BLANK;
      end else begin
         m1    <= {anode_in, seg_in};
         m2    <= m1;
         smp   <= smp_n;
         cnt   <= cnt_n;
         state <= state_n;
      end
   always_comb begin
      state_n = state;
      smp_n   = smp;
      cnt_n   = cnt;
      accept  = 1'b0;
      if (state == BLANK) begin
         smp_n   = m2;
         cnt_n   = one ? CW'(1) : '0;
         state_n = one ? SETTLE : BLANK;
      end else if (!same) begin
         smp_n   = m2;
         cnt_n   = CW'(1);
         state_n = one ? SETTLE : BLANK;
      end else if (state == SETTLE) begin
         cnt_n = (cnt == CW'(STABLE_CYCLES)) ? cnt : cnt + CW'(1);
         if (cnt_n == CW'(STABLE_CYCLES)) begin
            state_n = CAPTURED;
            accept  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers BCD digits from a multiplexed common-anode seven-segment bus
// Ports: clk, rst (sync, active-low); seg_in (a..g,dp active-low); anode_in (active-low);
// digits (BCD, digit i at [4i+3:4i]); dp; valid; err_pat (sticky); err_anode (sticky);
// upd (pulse on any digit write); frame_done (pulse once every digit was captured).
module seg_scan_decoder
   import seg7_pkg::*;
#(
   parameter int N_DIG          = 4,
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         seg_in,
   input  logic [N_DIG-1:0]   anode_in,
   output logic [4*N_DIG-1:0] digits,
   output logic [N_DIG-1:0]   dp,
   output logic [N_DIG-1:0]   valid,
   output logic [N_DIG-1:0]   err_pat,
   output logic               err_anode,
   output logic               upd,
   output logic               frame_done
);
   localparam int IW = N_DIG > 1 ? $clog2(N_DIG) : 1;
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [N_DIG-1:0] anode_s, smp_anode, hit, mask;
   logic [7:0]       smp_seg;
   logic             accept, multi;
   logic [IW-1:0]    idx;
   logic [3:0]       code;
   logic [CW-1:0]    mcnt;
   logic [TW-1:0]    tcnt [N_DIG];
   seg_sync_stable #(.N_DIG(N_DIG), .STABLE_CYCLES(STABLE_CYCLES)) u_sync (
      .clk       (clk),
      .rst       (rst),
      .seg_in    (seg_in),
      .anode_in  (anode_in),
      .anode_s   (anode_s),
      .smp_seg   (smp_seg),
      .smp_anode (smp_anode),
      .accept    (accept)
   );
   // Lowest low anode wins; only meaningful when accept guarantees a one-hot-low sample.
   always_comb begin
      idx = '0;
      for (int i = N_DIG - 1; i >= 0; i--)
         if (!smp_anode[i]) idx = IW'(i);
   end
   assign code  = seg7_decode(smp_seg[SEG_A:SEG_G]);
   assign hit   = accept ? (N_DIG'(1) << idx) : '0;
   assign multi = $countones(~anode_s) > 1;
   always_ff @(posedge clk)
      if (!rst) begin
         digits     <= '1;
         dp         <= '0;
         valid      <= '0;
         err_pat    <= '0;
         err_anode  <= 1'b0;
         upd        <= 1'b0;
         frame_done <= 1'b0;
         mcnt       <= '0;
         mask       <= '0;
         for (int i = 0; i < N_DIG; i++) tcnt[i] <= '0;
      end else begin
         upd        <= accept;
         frame_done <= &mask;
         // A full mask is cleared as frame_done fires; a same-cycle capture re-seeds it.
         mask       <= ((&mask) ? '0 : mask) | hit;
         mcnt       <= multi ? ((mcnt == CW'(STABLE_CYCLES)) ? mcnt : mcnt + CW'(1)) : '0;
         if (multi && mcnt == CW'(STABLE_CYCLES - 1)) err_anode <= 1'b1;
         for (int i = 0; i < N_DIG; i++)
            if (hit[i]) begin
               digits[4*i +: 4] <= code;
               dp[i]            <= ~smp_seg[SEG_DP];
               valid[i]         <= code != 4'hF;
               err_pat[i]       <= err_pat[i] | (code == 4'hF);
               tcnt[i]          <= '0;
            end else if (tcnt[i] != TW'(TIMEOUT_CYCLES)) begin
               tcnt[i] <= tcnt[i] + TW'(1);
               if (tcnt[i] == TW'(TIMEOUT_CYCLES - 1)) valid[i] <= 1'b0;
            end
      end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed, table-driven self-check of seg_scan_decoder
module tb_seg_scan_decoder;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  seg_in = 8'hFF;
   logic [3:0]  anode_in = 4'hF;
   logic [15:0] digits, t_digits;
   logic [3:0]  dp, valid, err_pat, t_dp, t_valid, t_err_pat;
   logic        err_anode, upd, frame_done, t_err_anode, t_upd, t_frame_done;
   int checks = 0, failures = 0;
   int cyc = 0, n_upd = 0, n_fd = 0, last_upd = 0, fd_cyc = 0, n_tupd = 0;
   logic saw3 = 1'b0;
   typedef struct { logic [7:0] seg; int idx; logic [3:0] d; logic p; } vec_t;
   vec_t tbl [10];
   logic [7:0] scan_seg [4];
   logic [15:0] snap;
   always #5 clk = ~clk;
   seg_scan_decoder dut (
      .clk(clk), .rst(rst), .seg_in(seg_in), .anode_in(anode_in),
      .digits(digits), .dp(dp), .valid(valid), .err_pat(err_pat),
      .err_anode(err_anode), .upd(upd), .frame_done(frame_done)
   );
   seg_scan_decoder #(.TIMEOUT_CYCLES(64)) dut_t (
      .clk(clk), .rst(rst), .seg_in(seg_in), .anode_in(anode_in),
      .digits(t_digits), .dp(t_dp), .valid(t_valid), .err_pat(t_err_pat),
      .err_anode(t_err_anode), .upd(t_upd), .frame_done(t_frame_done)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (upd) begin n_upd++; last_upd = cyc; end
      if (frame_done) begin n_fd++; fd_cyc = cyc; end
      if (t_upd) n_tupd++;
      if (digits[3:0] == 4'h3) saw3 = 1'b1;
   endtask
   task automatic drive(input logic [7:0] s, input logic [3:0] a, input int n);
      seg_in   = s;
      anode_in = a;
      repeat (n) tick();
   endtask
   initial begin
      tbl[0] = '{8'b0000001_0, 0, 4'h0, 1'b1};
      tbl[1] = '{8'b0100100_1, 1, 4'h5, 1'b0};
      tbl[2] = '{8'b0100000_0, 2, 4'h6, 1'b1};
      tbl[3] = '{8'b0001111_1, 3, 4'h7, 1'b0};
      tbl[4] = '{8'b0000000_1, 0, 4'h8, 1'b0};
      tbl[5] = '{8'b0000100_0, 1, 4'h9, 1'b1};
      tbl[6] = '{8'b0010010_1, 2, 4'h2, 1'b0};
      tbl[7] = '{8'b0000110_0, 3, 4'h3, 1'b1};
      tbl[8] = '{8'b1001100_1, 0, 4'h4, 1'b0};
      tbl[9] = '{8'b1001111_0, 1, 4'h1, 1'b1};
      scan_seg[3] = 8'b1001111_1;
      scan_seg[2] = 8'b0010010_1;
      scan_seg[1] = 8'b0000110_1;
      scan_seg[0] = 8'b1001100_1;
      // reset with a noisy bus
      rst = 1'b0;
      repeat (3) begin
         seg_in   = 8'($urandom);
         anode_in = 4'($urandom);
         tick();
      end
      chk("rst_digits", 32'(digits), 32'hFFFF);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_dp", 32'(dp), 32'h0);
      chk("rst_err", 32'({err_pat, err_anode}), 32'h0);
      chk("rst_pulses", 32'({upd, frame_done}), 32'h0);
      rst = 1'b1;
      n_upd = 0; n_fd = 0;
      drive(8'hFF, 4'hF, 5);
      chk("rst_no_upd", 32'(n_upd), 32'd0);
      // scan "1234"
      for (int k = 3; k >= 0; k--) begin
         drive(scan_seg[k], ~(4'b1 << k), 100);
         drive(8'hFF, 4'hF, 10);
      end
      chk("scan_upd_count", 32'(n_upd), 32'd4);
      chk("scan_digits", 32'(digits), 32'h1234);
      chk("scan_valid", 32'(valid), 32'hF);
      chk("scan_fd_count", 32'(n_fd), 32'd1);
      chk("scan_fd_timing", 32'(fd_cyc), 32'(last_upd + 1));
      // table of single-digit captures
      for (int v = 0; v < 10; v++) begin
         n_upd = 0;
         drive(tbl[v].seg, ~(4'b1 << tbl[v].idx), 40);
         chk($sformatf("tbl%0d_upd", v), 32'(n_upd), 32'd1);
         chk($sformatf("tbl%0d_digit", v), 32'(digits[4*tbl[v].idx +: 4]), 32'(tbl[v].d));
         chk($sformatf("tbl%0d_dp", v), 32'(dp[tbl[v].idx]), 32'(tbl[v].p));
         chk($sformatf("tbl%0d_valid", v), 32'(valid[tbl[v].idx]), 32'd1);
         drive(8'hFF, 4'hF, 10);
      end
      // glitch: 3 shown too briefly, then 8 settles
      n_upd = 0;
      saw3  = 1'b0;
      drive(8'b0000110_1, 4'b1110, 10);
      drive(8'b0000000_1, 4'b1110, 20);
      chk("glitch_upd", 32'(n_upd), 32'd1);
      chk("glitch_digit", 32'(digits[3:0]), 32'h8);
      chk("glitch_never3", 32'(saw3), 32'd0);
      drive(8'hFF, 4'hF, 10);
      // invalid pattern on digit 2, with the stability boundary
      n_upd = 0;
      drive(8'b1111110_1, 4'b1011, 17);
      chk("inv_no_upd_early", 32'(n_upd), 32'd0);
      drive(8'b1111110_1, 4'b1011, 3);
      chk("inv_upd", 32'(n_upd), 32'd1);
      chk("inv_err_pat", 32'(err_pat), 32'h4);
      chk("inv_valid2", 32'(valid[2]), 32'd0);
      chk("inv_digit2", 32'(digits[11:8]), 32'hF);
      drive(8'hFF, 4'hF, 10);
      // two anodes low
      snap  = digits;
      n_upd = 0;
      drive(8'b0000000_1, 4'b1100, 17);
      chk("multi_err_early", 32'(err_anode), 32'd0);
      drive(8'b0000000_1, 4'b1100, 3);
      chk("multi_err", 32'(err_anode), 32'd1);
      chk("multi_no_upd", 32'(n_upd), 32'd0);
      chk("multi_digits", 32'(digits), 32'(snap));
      drive(8'hFF, 4'hF, 10);
      chk("multi_sticky", 32'(err_anode), 32'd1);
      // timeout on the short-timeout instance
      n_tupd = 0;
      seg_in   = 8'b0001111_1;
      anode_in = 4'b1110;
      for (int b = 0; b < 40 && n_tupd == 0; b++) tick();
      chk("to_capture", 32'(n_tupd), 32'd1);
      seg_in   = 8'hFF;
      anode_in = 4'hF;
      repeat (63) tick();
      chk("to_valid_before", 32'(t_valid[0]), 32'd1);
      tick();
      chk("to_valid_after", 32'(t_valid[0]), 32'd0);
      chk("to_digit_held", 32'(t_digits[3:0]), 32'h7);
      chk("to_no_upd", 32'(n_tupd), 32'd1);
      // reset in the middle of a capture
      n_upd = 0;
      drive(8'b0100100_1, 4'b1101, 10);
      rst = 1'b0;
      drive(8'b0100100_1, 4'b1101, 2);
      chk("midrst_digits", 32'(digits), 32'hFFFF);
      chk("midrst_flags", 32'({valid, err_pat, err_anode}), 32'h0);
      rst = 1'b1;
      drive(8'hFF, 4'hF, 25);
      chk("midrst_no_upd", 32'(n_upd), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the team's seven-segment display drivers: it monitors a multiplexed common-anode display bus (segment and anode lines) and recovers the shown digits as BCD.
- Used as an on-board self-check and loopback monitor: digit outputs feed the checker/LEDs, and error flags expose bad patterns or a stalled scan.
- Sits between the pad-level display bus and the system logic, in the single clk domain.

Parameters:
- N_DIG, 4, number of multiplexed digits/anode lines.
- STABLE_CYCLES, 16, consecutive identical samples required before a pattern is accepted (2..255).
- TIMEOUT_CYCLES, 1048576, cycles without a refresh before a digit's valid bit clears.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- seg_in  in  8  segment bus, active-low, bit7..bit0 = a,b,c,d,e,f,g,dp.
- anode_in  in  N_DIG  anode enables, active-low; exactly one low selects a digit.
- digits  out  4*N_DIG  recovered BCD, digit i at [4i+3:4i].
- dp  out  N_DIG  decimal point per digit, 1 = lit.
- valid  out  N_DIG  digit i captured and refreshed within the timeout.
- err_pat  out  N_DIG  sticky: undecodable pattern seen on digit i.
- err_anode  out  1  sticky: more than one anode low for at least STABLE_CYCLES.
- upd  out  1  one-cycle pulse when any digit register is written.
- frame_done  out  1  one-cycle pulse when all N_DIG digits are captured since the last pulse.

Behaviour:
- Reset (rst=0 at a clk edge):
  - digits=all 0xF, dp=0, valid=0, err_pat=0, err_anode=0, upd=0, frame_done=0.
  - FSM=BLANK; stability counter=0; frame mask=0; timeout counters=0; synchronizers cleared to all-1.
  - Reset mid-capture discards the partial sample with no upd.
- Input path: seg_in and anode_in each pass through a 2-flop synchronizer. All decisions use the synchronized values (2-cycle input latency).
- Decode table (abcdefg, 0=lit):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Any other pattern decodes to 0xF (invalid). dp = ~seg[0].
- FSM states:
  - BLANK: anodes all high or more than one low. Move to SETTLE when exactly one anode is low. Load the sample and set count=1.
  - SETTLE: each cycle with sample == previous sample, count+1. Any change reloads the sample, sets count=1, and returns to BLANK if the anode is no longer one-hot-low.
    - When count reaches STABLE_CYCLES, go to CAPTURED.
    - In the same cycle as the transition: write digits[i] and dp[i], set valid[i], clear timeout[i], pulse upd, set frame mask bit i.
    - If the decode is invalid: digits[i]=0xF, valid[i]=0, err_pat[i]=1, upd still pulses.
  - CAPTURED: no writes while the sample is unchanged.
    - Any change: go to SETTLE with count=1, or to BLANK if the anode is no longer one-hot-low.
    - Re-lighting the same digit re-captures it (refresh).
- Multi-anode: while more than one anode is low, a separate counter runs. It sets err_anode at STABLE_CYCLES. No digit is written.
- Frame:
  - When the frame mask becomes all-ones, pulse frame_done in the cycle after the completing upd, and clear the mask in that same cycle.
  - If a digit is captured in that same cycle, its bit is OR'd into the cleared mask.
- Timeout:
  - Per-digit saturating counter, incremented every cycle.
  - On reaching TIMEOUT_CYCLES: clear valid[i]; digits[i] holds its last value; no upd.
  - A capture in the same cycle wins: valid stays 1 and the counter reloads to 0.
- err flags are sticky and clear only on reset.
- Widths:
  - Stability counter is clog2(STABLE_CYCLES+1) bits and saturates.
  - Timeout counters are clog2(TIMEOUT_CYCLES+1) bits.
  - Anode index comes from a priority encoder, used only when the anodes are one-hot-low.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_* pattern constants for 0–9 and blank, plus segment bit-index constants.
  - A decode function (pattern to BCD/0xF) and the matching encode function, used by drivers and by the bench.
  - The FSM state typedef {BLANK, SETTLE, CAPTURED}.
- One sub-module, seg_sync_stable: 2-flop synchronizer plus stability counter. It outputs the stable sample and a one-cycle accept pulse.
- Top level handles the anode index, decode, per-digit registers, timeouts and frame logic.

Test Plan:
- Reset: hold rst=0 for 3 clks with random bus values -> digits=16'hFFFF, valid=0, no upd/frame_done.
- Scan "1234" (digit3..0), 100 cycles per digit, 10 blank cycles between digits -> exactly 4 upd pulses, digits=16'h1234, valid=4'hF, frame_done 1 cycle after the 4th upd.
- Glitch: present seg=0000110_1 for 10 cycles, then 0000000_1 for 20 cycles on anode 0 (STABLE_CYCLES=16) -> one upd, digits[3:0]=8, never 3.
- Invalid: pattern 1111110_1 ("-") on digit 2 for 20 cycles -> err_pat[2]=1, valid[2]=0, digits[11:8]=F, upd pulses once.
- Two anodes low (4'b1100) for 20 cycles -> err_anode=1, no upd, digit registers unchanged.
- Timeout (TIMEOUT_CYCLES=64 in the bench): capture digit 0 = 7, then hold all anodes high for 64 cycles -> valid[0] clears on cycle 64, digits[3:0] stays 7.
